// File: rtl/toycpu_prog_loader.sv
// Boot loader: receives an A5/LEN/words byte frame and writes 16-bit words into instruction RAM, holding the CPU in reset until done.
// Optional feature macro CHECKSUM_EN: a trailing sum8 byte must bring the frame sum to zero before the CPU is released.
module toycpu_prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int                TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]     TMO_ONE  = TW'(1);
  localparam logic [16:0]       MAX_LEN  = 17'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]   WC_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [7:0]        SYNC     = 8'hA5;

  typedef enum logic [2:0] {
    S_WAIT_SYNC,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_RUN,
    S_ERR
`ifdef CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [7:0]        lo_q, lo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              done_q, done_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [TW-1:0]     tmo_q, tmo_d;
`ifdef CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic              accept;
  logic              in_frame;
  logic              timeout_hit;
  logic              last_word;
  logic [15:0]       len16;
  logic              bad_len;

  assign in_frame    = !(state_q == S_WAIT_SYNC || state_q == S_RUN || state_q == S_ERR);
  assign rx_ready    = !(state_q == S_RUN || state_q == S_ERR);
  assign accept      = rx_valid && rx_ready;
  assign timeout_hit = in_frame && !accept && (tmo_q == TMO_LAST);
  assign last_word   = (wc_q == (len_q - WC_ONE));
  assign len16       = {rx_data, len_lo_q};
  assign bad_len     = (len16 == 16'h0000) || ({1'b0, len16} > MAX_LEN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_WAIT_SYNC;
      len_lo_q  <= '0;
      len_q     <= '0;
      lo_q      <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wc_q      <= '0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
      tmo_q     <= '0;
`ifdef CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      lo_q      <= lo_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wc_q      <= wc_d;
      done_q    <= done_d;
      cpu_rst_q <= cpu_rst_d;
      tmo_q     <= tmo_d;
`ifdef CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    lo_d     = lo_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wc_d     = wc_q;
    tmo_d    = (accept || !in_frame) ? '0 : tmo_q + TMO_ONE;
`ifdef CHECKSUM_EN
    sum_d    = (state_q == S_WAIT_SYNC) ? 8'h00 : (accept ? sum_q + rx_data : sum_q);
`endif

    // Index advances after its pulse; it parks on the last word so it never wraps.
    if (we_q) begin
      wc_d = wc_q + WC_ONE;
      if ((wc_q + WC_ONE) < len_q) begin
        addr_d = addr_q + ADDR_ONE;
      end
    end

    case (state_q)
      S_WAIT_SYNC: begin
        if (accept && rx_data == SYNC) begin
          wc_d    = '0;
          addr_d  = '0;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          if (bad_len) begin
            state_d = S_ERR;
          end else begin
            len_d   = len16[ADDR_W:0];
            state_d = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          lo_d    = rx_data;
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          we_d    = 1'b1;
          wdata_d = {rx_data, lo_q};
`ifdef CHECKSUM_EN
          state_d = last_word ? S_CHK : S_DATA_LO;
`else
          state_d = last_word ? S_RUN : S_DATA_LO;
`endif
        end
      end
`ifdef CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d = (sum_d == 8'h00) ? S_RUN : S_ERR;
        end
      end
`endif
      S_RUN: begin
        if (start) begin
          state_d = S_WAIT_SYNC;
        end
      end
      S_ERR: begin
        if (start) begin
          state_d = S_WAIT_SYNC;
        end
      end
      default: state_d = S_WAIT_SYNC;
    endcase

    if (timeout_hit) begin
      state_d = S_ERR;
    end

    // Release waits until the final write pulse has gone out.
    done_d    = (state_d == S_RUN) && !we_d;
    cpu_rst_d = !done_d;
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = in_frame;
  assign done       = done_q;
  assign error      = (state_q == S_ERR);
  assign word_count = wc_q;

endmodule

// File: tb/tb_toycpu_prog_loader.sv
// Directed bench for toycpu_prog_loader: cycle table for a back-to-back frame plus hand sequences for errors, timeout and reset.
// Build with CHECKSUM_EN defined to exercise the checksum byte.
module tb_toycpu_prog_loader;

  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              start = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  toycpu_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .start(start), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        exp_we;
    logic [3:0]  exp_addr;
    logic        chk_addr;
    logic [15:0] exp_wdata;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_cpu_rst;
    logic [4:0]  exp_wc;
    logic        exp_ready;
  } vec_t;

  vec_t              vecs[11];
  int                errors = 0;
  int                checks = 0;
  logic [15:0]       wr_data[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [15:0]       frame_w[16];
  logic [15:0]       exp_w[16];

  always @(negedge clk) begin
    if (rst && imem_we) begin
      wr_data.push_back(imem_wdata);
      wr_addr.push_back(imem_addr);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Sends one byte, waiting (bounded) for rx_ready; returns on the negedge after the accepting edge.
  task automatic applyStimulus(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = rx_ready;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    checkOutput($sformatf("accept_%02h", b), acc, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    for (int k = 0; k < max_cycles && !done; k++) @(negedge clk);
    checkOutput({name, "_done"}, done, 1'b1);
  endtask

  task automatic send_frame(input logic [15:0] len, input int nwords);
    logic [7:0] sum;
    sum = len[7:0] + len[15:8];
    applyStimulus(8'hA5);
    applyStimulus(len[7:0]);
    applyStimulus(len[15:8]);
    for (int i = 0; i < nwords; i++) begin
      applyStimulus(frame_w[i][7:0]);
      applyStimulus(frame_w[i][15:8]);
      sum = sum + frame_w[i][7:0] + frame_w[i][15:8];
    end
`ifdef CHECKSUM_EN
    applyStimulus(8'h00 - sum);
`endif
  endtask

  task automatic check_log(input string name, input int n);
    checkOutput({name, "_nwrites"}, wr_data.size(), n);
    for (int i = 0; i < n && i < wr_data.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", name, i), wr_addr[i], i);
      checkOutput($sformatf("%s_data%0d", name, i), wr_data[i], exp_w[i]);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] d, input logic v, input logic we,
                         input logic [3:0] a, input logic ca, input logic [15:0] wd, input logic b,
                         input logic dn, input logic cr, input logic [4:0] wc, input logic rdy);
    vecs[i].data = d;  vecs[i].valid = v; vecs[i].exp_we = we; vecs[i].exp_addr = a;
    vecs[i].chk_addr = ca; vecs[i].exp_wdata = wd; vecs[i].exp_busy = b; vecs[i].exp_done = dn;
    vecs[i].exp_cpu_rst = cr; vecs[i].exp_wc = wc; vecs[i].exp_ready = rdy;
  endtask

  initial begin
    //           i  data  v  we addr ca wdata    busy done crst wc rdy
    set_vec( 0, 8'hA5, 1, 0, 4'd0, 1, 16'h0000, 0, 0, 1, 5'd0, 1);
    set_vec( 1, 8'h03, 1, 0, 4'd0, 1, 16'h0000, 1, 0, 1, 5'd0, 1);
    set_vec( 2, 8'h00, 1, 0, 4'd0, 1, 16'h0000, 1, 0, 1, 5'd0, 1);
    set_vec( 3, 8'h80, 1, 0, 4'd0, 1, 16'h0000, 1, 0, 1, 5'd0, 1);
    set_vec( 4, 8'h00, 1, 0, 4'd0, 1, 16'h0000, 1, 0, 1, 5'd0, 1);
    set_vec( 5, 8'h01, 1, 1, 4'd0, 1, 16'h0080, 1, 0, 1, 5'd0, 1);
    set_vec( 6, 8'h01, 1, 0, 4'd1, 1, 16'h0000, 1, 0, 1, 5'd1, 1);
    set_vec( 7, 8'h34, 1, 1, 4'd1, 1, 16'h0101, 1, 0, 1, 5'd1, 1);
    set_vec( 8, 8'h12, 1, 0, 4'd2, 1, 16'h0000, 1, 0, 1, 5'd2, 1);
`ifdef CHECKSUM_EN
    set_vec( 9, 8'h35, 1, 1, 4'd2, 1, 16'h1234, 1, 0, 1, 5'd2, 1);
`else
    set_vec( 9, 8'h00, 0, 1, 4'd2, 1, 16'h1234, 0, 0, 1, 5'd2, 0);
`endif
    set_vec(10, 8'h00, 0, 0, 4'd0, 0, 16'h0000, 0, 1, 0, 5'd3, 0);

    repeat (3) @(negedge clk);
    rst = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_cpu_rst", cpu_rst, 1'b1);
    checkOutput("rst_we", imem_we, 1'b0);
    checkOutput("rst_addr", imem_addr, 0);
    checkOutput("rst_wdata", imem_wdata, 16'h0000);
    checkOutput("rst_error", error, 1'b0);
    checkOutput("rst_ready", rx_ready, 1'b1);

    $display("[TB] back-to-back frame, cycle table");
    for (int i = 0; i < 11; i++) begin
      checkOutput($sformatf("row%0d_we", i), imem_we, vecs[i].exp_we);
      checkOutput($sformatf("row%0d_busy", i), busy, vecs[i].exp_busy);
      checkOutput($sformatf("row%0d_done", i), done, vecs[i].exp_done);
      checkOutput($sformatf("row%0d_cpu_rst", i), cpu_rst, vecs[i].exp_cpu_rst);
      checkOutput($sformatf("row%0d_wc", i), word_count, vecs[i].exp_wc);
      checkOutput($sformatf("row%0d_ready", i), rx_ready, vecs[i].exp_ready);
      if (vecs[i].chk_addr) checkOutput($sformatf("row%0d_addr", i), imem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_we) checkOutput($sformatf("row%0d_wdata", i), imem_wdata, vecs[i].exp_wdata);
      rx_data  = vecs[i].data;
      rx_valid = vecs[i].valid;
      @(negedge clk);
    end
    rx_valid = 1'b0;

    $display("[TB] start in RUN");
    pulse_start();
    checkOutput("restart_cpu_rst", cpu_rst, 1'b1);
    checkOutput("restart_done", done, 1'b0);
    checkOutput("restart_ready", rx_ready, 1'b1);

    $display("[TB] leading junk bytes");
    wr_data.delete(); wr_addr.delete();
    applyStimulus(8'h00); idle(2);
    applyStimulus(8'hFF); idle(1);
    applyStimulus(8'h5A);
    checkOutput("junk_busy", busy, 1'b0);
    frame_w[0] = 16'h0080; frame_w[1] = 16'h0101; frame_w[2] = 16'h1234;
    exp_w[0]   = 16'h0080; exp_w[1]   = 16'h0101; exp_w[2]   = 16'h1234;
    send_frame(16'd3, 3);
    wait_done("junk", 10);
    check_log("junk", 3);
    checkOutput("junk_wc", word_count, 3);
    checkOutput("junk_cpu_rst", cpu_rst, 1'b0);

    $display("[TB] zero length frame");
    pulse_start();
    wr_data.delete(); wr_addr.delete();
    applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h00);
    checkOutput("len0_error", error, 1'b1);
    checkOutput("len0_ready", rx_ready, 1'b0);
    checkOutput("len0_cpu_rst", cpu_rst, 1'b1);
    checkOutput("len0_nwrites", wr_data.size(), 0);
    pulse_start();
    checkOutput("clr_error", error, 1'b0);
    checkOutput("clr_ready", rx_ready, 1'b1);
    frame_w[0] = 16'hABCD; exp_w[0] = 16'hABCD;
    send_frame(16'd1, 1);
    wait_done("after_err", 10);
    check_log("after_err", 1);
    checkOutput("after_err_wc", word_count, 1);

    $display("[TB] length limits");
    pulse_start();
    applyStimulus(8'hA5); applyStimulus(8'h11); applyStimulus(8'h00);
    checkOutput("len17_error", error, 1'b1);
    pulse_start();
    idle(12);
    checkOutput("sync_idle_error", error, 1'b0);
    wr_data.delete(); wr_addr.delete();
    for (int i = 0; i < 16; i++) begin
      frame_w[i] = 16'h1000 + 16'(i) * 16'h0101;
      exp_w[i]   = 16'h1000 + 16'(i) * 16'h0101;
    end
    send_frame(16'd16, 16);
    wait_done("len16", 10);
    check_log("len16", 16);
    checkOutput("len16_wc", word_count, 16);
    idle(12);
    checkOutput("run_idle_error", error, 1'b0);
    checkOutput("run_idle_done", done, 1'b1);

    $display("[TB] timeout");
    pulse_start();
    wr_data.delete(); wr_addr.delete();
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h34);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      checkOutput($sformatf("tmo_early%0d", k), error, 1'b0);
    end
    @(negedge clk);
    checkOutput("tmo_error", error, 1'b1);
    checkOutput("tmo_ready", rx_ready, 1'b0);
    checkOutput("tmo_cpu_rst", cpu_rst, 1'b1);
    checkOutput("tmo_nwrites", wr_data.size(), 0);
    pulse_start();

`ifdef CHECKSUM_EN
    $display("[TB] checksum");
    wr_data.delete(); wr_addr.delete();
    exp_w[0] = 16'h1234;
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h00);
    applyStimulus(8'h34); applyStimulus(8'h12); applyStimulus(8'hB9);
    checkOutput("ck_good_cpu_rst", cpu_rst, 1'b0);
    checkOutput("ck_good_done", done, 1'b1);
    check_log("ck_good", 1);
    pulse_start();
    wr_data.delete(); wr_addr.delete();
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h00);
    applyStimulus(8'h34); applyStimulus(8'h12); applyStimulus(8'hB8);
    checkOutput("ck_bad_error", error, 1'b1);
    checkOutput("ck_bad_cpu_rst", cpu_rst, 1'b1);
    check_log("ck_bad", 1);
    pulse_start();
`endif

    $display("[TB] reset mid-frame");
    wr_data.delete(); wr_addr.delete();
    applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'h00);
    applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
    checkOutput("mid_wc", word_count, 1);
    checkOutput("mid_busy", busy, 1'b1);
    exp_w[0] = 16'h2211;
    check_log("mid", 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_cpu_rst", cpu_rst, 1'b1);
    checkOutput("arst_we", imem_we, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_ready", rx_ready, 1'b1);
    checkOutput("arst_wc", word_count, 0);
    @(negedge clk);
    rst = 1'b1;
    wr_data.delete(); wr_addr.delete();
    frame_w[0] = 16'h5678; exp_w[0] = 16'h5678;
    send_frame(16'd1, 1);
    wait_done("post_rst", 10);
    check_log("post_rst", 1);
    checkOutput("post_rst_cpu_rst", cpu_rst, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
